// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared size codes, FSM states and misalignment rule for mem_lsu
package mem_lsu_pkg;

    localparam logic [1:0] MEM_SZ_B = 2'b00;
    localparam logic [1:0] MEM_SZ_H = 2'b01;
    localparam logic [1:0] MEM_SZ_W = 2'b10;

    // Wide enough for the largest supported timeout (1023).
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

    // Reserved size 2'b11 falls through to the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        if (size == MEM_SZ_B) begin
            mis = 1'b0;
        end else if (size == MEM_SZ_H) begin
            mis = lo[0];
        end else begin
            mis = (lo != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// rtl/mem_lsu_align.sv - byte-lane strobes, store replication, misalign flag and load extract/extend
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        uns,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  strb,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic [31:0] ld_ext
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b   = 8'(rdata >> {addr_lo, 3'b000});
        lane_h   = 16'(rdata >> {addr_lo[1], 4'b0000});
        misalign = is_misaligned(size, addr_lo);
        strb     = 4'hF;
        wdata    = st_data;
        ld_ext   = rdata;
        case (size)
            MEM_SZ_B: begin
                strb   = 4'b0001 << addr_lo;
                wdata  = {4{st_data[7:0]}};
                ld_ext = uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            end
            MEM_SZ_H: begin
                strb   = 4'b0011 << addr_lo;
                wdata  = {2{st_data[15:0]}};
                ld_ext = uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            end
            default: begin
                strb   = 4'hF;
                wdata  = st_data;
                ld_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store stage: req/ack bus master with stall, timeout and load extension
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_uns,
    input  logic [31:0] alu_c,
    input  logic [31:0] rf_rd2,
    output logic        lsu_stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [3:0]        strb_q, strb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       ld_data_q, ld_data_d;
    logic              ld_valid_q, ld_valid_d;
    logic              bus_err_q, bus_err_d;
    logic              bus_req_q, bus_req_d;

    logic [1:0]        sel_size;
    logic [1:0]        sel_lo;
    logic [3:0]        al_strb;
    logic [31:0]       al_wdata;
    logic              al_mis;
    logic [31:0]       al_ld;

    // The aligner sees the live request in IDLE and the latched one while the bus cycle runs.
    assign sel_size = (state_q == LSU_IDLE) ? mem_size : size_q;
    assign sel_lo   = (state_q == LSU_IDLE) ? alu_c[1:0] : addr_q[1:0];

    mem_lsu_align u_align (
        .size     (sel_size),
        .addr_lo  (sel_lo),
        .uns      (uns_q),
        .st_data  (rf_rd2),
        .rdata    (bus_rdata),
        .strb     (al_strb),
        .wdata    (al_wdata),
        .misalign (al_mis),
        .ld_ext   (al_ld)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        strb_d     = strb_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        uns_d      = uns_q;
        ld_data_d  = ld_data_q;
        ld_valid_d = 1'b0;
        bus_err_d  = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (mem_en && !al_mis) begin
                    state_d = LSU_REQ;
                    cnt_d   = '0;
                    addr_d  = alu_c;
                    we_d    = mem_we;
                    strb_d  = mem_we ? al_strb : 4'h0;
                    wdata_d = al_wdata;
                    size_d  = mem_size;
                    uns_d   = mem_uns;
                end
            end
            LSU_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_ack) begin
                    state_d = LSU_DONE;
                    if (!we_q) begin
                        ld_data_d  = al_ld;
                        ld_valid_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = LSU_DONE;
                    bus_err_d = 1'b1;
                    if (!we_q) begin
                        ld_data_d = '0;
                    end
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
        bus_req_d = (state_d == LSU_REQ);
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q    <= LSU_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            strb_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
            bus_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            strb_q     <= strb_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
            bus_err_q  <= bus_err_d;
            bus_req_q  <= bus_req_d;
        end
    end

    // Stall and misalign react to mem_en in the same cycle so the core never loses an edge.
    assign lsu_stall = !cpu_rst && ((state_q == LSU_REQ) ||
                                    (state_q == LSU_IDLE && mem_en && !al_mis));
    assign misalign  = !cpu_rst && (state_q == LSU_IDLE) && mem_en && al_mis;

    assign ld_data   = ld_data_q;
    assign ld_valid  = ld_valid_q;
    assign bus_err   = bus_err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = we_q;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_wstrb = strb_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - randomized self-checking bench for mem_lsu against a transaction-level model
module tb_mem_lsu;

    localparam int TO = 8;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        mem_en, mem_we, mem_uns;
    logic [1:0]  mem_size;
    logic [31:0] alu_c, rf_rd2;
    logic        lsu_stall, ld_valid, misalign, bus_err, bus_req, bus_we;
    logic [31:0] ld_data, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;

    int checks = 0;
    int errors = 0;
    logic check_en = 1'b0;

    logic        e_stall = 0, e_valid = 0, e_mis = 0, e_err = 0, e_req = 0, e_we = 0;
    logic [31:0] e_ld = 0, e_addr = 0, e_wdata = 0;
    logic [3:0]  e_strb = 0;

    int          stall_cnt = 0, valid_cnt = 0, err_cnt = 0, req_cnt = 0, mis_cnt = 0;
    logic [3:0]  last_strb = 0;
    logic [31:0] last_wdata = 0, last_addr = 0;

    always #5 cpu_clk = ~cpu_clk;

    mem_lsu #(.TIMEOUT_CYC(TO)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .mem_en(mem_en), .mem_we(mem_we),
        .mem_size(mem_size), .mem_uns(mem_uns), .alu_c(alu_c), .rf_rd2(rf_rd2),
        .lsu_stall(lsu_stall), .ld_data(ld_data), .ld_valid(ld_valid), .misalign(misalign),
        .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [3:0] ref_strb(input logic [1:0] sz, input logic [31:0] a);
        int k;
        k = int'(a % 4);
        if (sz == 2'd0) return 4'(1 << k);
        if (sz == 2'd1) return 4'(3 << k);
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        int k;
        k = int'(a % 4);
        if (sz == 2'd0) begin
            v = (rd >> (8 * k)) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (8 * k)) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    always @(negedge cpu_clk) begin
        if (lsu_stall) stall_cnt++;
        if (ld_valid) valid_cnt++;
        if (bus_err) err_cnt++;
        if (misalign) mis_cnt++;
        if (bus_req) begin
            req_cnt++;
            last_strb  = bus_wstrb;
            last_wdata = bus_wdata;
            last_addr  = bus_addr;
        end
        if (check_en) begin
            chk("lsu_stall", lsu_stall, e_stall);
            chk("ld_valid", ld_valid, e_valid);
            chk("misalign", misalign, e_mis);
            chk("bus_err", bus_err, e_err);
            chk("bus_req", bus_req, e_req);
            chk("ld_data", ld_data, e_ld);
            if (e_req) begin
                chk("bus_we", bus_we, e_we);
                chk("bus_addr", bus_addr, e_addr);
                chk("bus_wstrb", bus_wstrb, e_strb);
                chk("bus_wdata", bus_wdata, e_wdata);
            end
        end
    end

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    // ack_at = REQ cycle number carrying the ack; 0 means no ack (timeout).
    task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d,
                         input int ack_at, input logic [31:0] rdat);
        logic mis;
        logic acked;
        mis   = ref_mis(sz, a);
        acked = 1'b0;
        mem_en = 1'b1; mem_we = we; mem_size = sz; mem_uns = uns; alu_c = a; rf_rd2 = d;
        bus_ack = 1'b0; bus_rdata = $urandom;
        e_valid = 0; e_err = 0; e_req = 0; e_mis = mis; e_stall = !mis;
        step();
        if (mis) begin
            mem_en = 1'b0; e_mis = 0; e_stall = 0;
            return;
        end
        e_mis = 0; e_stall = 1; e_req = 1; e_we = we;
        e_addr = a & ~32'h3;
        e_strb = we ? ref_strb(sz, a) : 4'h0;
        e_wdata = ref_wdata(sz, d);
        for (int n = 1; n <= TO; n++) begin
            bus_ack = (n == ack_at);
            bus_rdata = bus_ack ? rdat : $urandom;
            alu_c = $urandom; rf_rd2 = $urandom; mem_size = 2'($urandom);
            mem_uns = 1'($urandom); mem_we = 1'($urandom);
            step();
            if (n == ack_at) begin
                acked = 1'b1;
                break;
            end
        end
        bus_ack = 1'b0;
        e_stall = 0; e_req = 0;
        e_valid = !we && acked;
        e_err = !acked;
        if (!we) e_ld = acked ? ref_load(sz, uns, a, rdat) : 32'h0;
        step();
        mem_en = 1'b0; e_valid = 0; e_err = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            mem_en = 1'b0; alu_c = $urandom; rf_rd2 = $urandom; mem_size = 2'($urandom);
            bus_ack = ($urandom % 4 == 0); bus_rdata = $urandom;
            e_stall = 0; e_mis = 0; e_req = 0; e_valid = 0; e_err = 0;
            step();
        end
        bus_ack = 1'b0;
    endtask

    int base_a, base_b, base_c;

    initial begin
        cpu_rst = 1'b1; mem_en = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_uns = 1'b0;
        alu_c = 0; rf_rd2 = 0; bus_ack = 1'b0; bus_rdata = 0;
        step();
        step();
        check_en = 1'b1;
        step();
        chk("rst_ld_data", ld_data, 32'h0);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_wstrb", bus_wstrb, 4'h0);
        cpu_rst = 1'b0;
        idle(2);

        base_a = stall_cnt;
        do_op(1'b1, 2'd2, 1'b0, 32'h100, 32'h1234_5678, 3, 32'h0);
        chk("t1_stall_cycles", stall_cnt - base_a, 4);
        chk("t1_strb", last_strb, 4'hF);
        chk("t1_wdata", last_wdata, 32'h1234_5678);
        chk("t1_addr", last_addr, 32'h100);

        base_a = valid_cnt;
        do_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1, 32'h80FF_0000);
        chk("t2_lb", ld_data, 32'hFFFF_FF80);
        chk("t2_valid_pulses", valid_cnt - base_a, 1);
        do_op(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 2, 32'h80FF_0000);
        chk("t2_lbu", ld_data, 32'h0000_0080);

        do_op(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_ABCD, 2, 32'h0);
        chk("t3_sh_strb", last_strb, 4'b1100);
        chk("t3_sh_wdata", last_wdata, 32'hABCD_ABCD);
        do_op(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 1, 32'h8001_1234);
        chk("t3_lh", ld_data, 32'hFFFF_8001);
        idle(1);

        base_a = req_cnt; base_b = mis_cnt;
        do_op(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 1, 32'h0);
        do_op(1'b1, 2'd1, 1'b0, 32'h001, 32'h5555, 1, 32'h0);
        chk("t4_req_cycles", req_cnt - base_a, 0);
        chk("t4_misalign_pulses", mis_cnt - base_b, 2);
        idle(1);

        base_a = req_cnt; base_b = err_cnt; base_c = valid_cnt;
        do_op(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 0, 32'h0);
        chk("t5_req_cycles", req_cnt - base_a, TO);
        chk("t5_err_pulses", err_cnt - base_b, 1);
        chk("t5_no_valid", valid_cnt - base_c, 0);
        chk("t5_ld_data", ld_data, 32'h0);
        do_op(1'b0, 2'd2, 1'b0, 32'h108, 32'h0, TO, 32'hCAFE_F00D);
        chk("t5_ack_on_last", ld_data, 32'hCAFE_F00D);
        idle(1);

        // Reset in the second REQ cycle, then a late ack the cycle after.
        mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_uns = 1'b0; alu_c = 32'h200;
        e_stall = 1; e_req = 0;
        step();
        e_req = 1; e_we = 0; e_addr = 32'h200; e_strb = 4'h0; e_wdata = rf_rd2;
        step();
        cpu_rst = 1'b1; check_en = 1'b0;
        step();
        cpu_rst = 1'b0; check_en = 1'b1; mem_en = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
        e_stall = 0; e_req = 0; e_valid = 0; e_err = 0; e_ld = 32'h0;
        base_a = valid_cnt;
        chk("t6_req_after_rst", bus_req, 1'b0);
        step();
        bus_ack = 1'b0;
        step();
        chk("t6_no_valid", valid_cnt - base_a, 0);

        for (int i = 0; i < 200; i++) begin
            logic        we, uns;
            logic [1:0]  sz;
            logic [31:0] a;
            int          ack_at;
            we  = 1'($urandom);
            uns = 1'($urandom);
            sz  = 2'($urandom);
            a   = $urandom;
            if ($urandom % 4 != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                else if (sz != 2'd0) a[1:0] = 2'b00;
            end
            ack_at = we ? 1 + int'($urandom % TO) : int'($urandom % (TO + 1));
            do_op(we, sz, uns, a, $urandom, ack_at, $urandom);
            idle(int'($urandom % 3));
        end

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
